tristate_bus_reader: RTL and testbench

- Receive-side controller for a shared tristate bus whose drivers each register a level `enable` and return `control_signal` (their registered enable) one clock later.
- Arbitrates N_SRC driver requests round-robin and issues a one-hot grant into the chosen driver's `enable`.
- Waits for that driver's `control_signal`, captures `bus_data`, and presents the word downstream on a valid/ready handshake.
- Flags timeouts and bus contention (more than one driver enabled).

---
 rtl/tristate_bus_reader_pkg.sv | 34 +++
 rtl/tristate_bus_reader_if.sv | 32 +++
 rtl/tristate_bus_reader_rr_arbiter.sv | 38 +++
 rtl/tristate_bus_reader.sv | 128 ++++++++++++
 tb/tb_tristate_bus_reader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/tristate_bus_reader_pkg.sv
// Shared definitions for the tristate bus reader: FSM encoding, default sizes
// and small vector helpers used by the controller.
package tristate_bus_reader_pkg;

  localparam int DEF_N_BITS = 32;
  localparam int DEF_N_SRC  = 4;

  // Helpers are sized for the largest legal driver count; callers cast.
  localparam int MAX_SRC   = 16;
  localparam int MAX_SRC_W = 4;

  typedef logic [MAX_SRC-1:0]   src_vec_t;
  typedef logic [MAX_SRC_W-1:0] src_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic src_vec_t onehot(input src_idx_t idx);
    src_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_gt1(input src_vec_t vec);
    return |(vec & (vec - 1'b1));
  endfunction

endpackage

// File: rtl/tristate_bus_reader_if.sv
// Bus-side and downstream-side signal bundle of the tristate bus reader.
interface tristate_bus_reader_if
  import tristate_bus_reader_pkg::*;
#(
  parameter int N_BITS = DEF_N_BITS,
  parameter int N_SRC  = DEF_N_SRC
);

  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]  req;
  logic [N_SRC-1:0]  grant;
  logic [N_SRC-1:0]  bus_ctl;
  logic [N_BITS-1:0] bus_data;
  logic [N_BITS-1:0] out_data;
  logic [SRC_W-1:0]  out_src;
  logic              out_valid;
  logic              out_ready;

  // The reader side.
  modport master (
    input  req, bus_ctl, bus_data, out_ready,
    output grant, out_data, out_src, out_valid
  );

  // Drivers plus downstream consumer.
  modport slave (
    output req, bus_ctl, bus_data, out_ready,
    input  grant, out_data, out_src, out_valid
  );

endinterface

// File: rtl/tristate_bus_reader_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_SRC = 4,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] sel,
  output logic             found
);

  logic             hi_found;
  logic [SRC_W-1:0] hi_sel;
  logic [SRC_W-1:0] lo_sel;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    found    = 1'b0;
    // Descending scan: the last hit wins, i.e. the lowest index overall
    // and the lowest index at or above the pointer.
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (req[j]) begin
        found  = 1'b1;
        lo_sel = SRC_W'(j);
        if (j >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_sel   = SRC_W'(j);
        end
      end
    end
    sel = hi_found ? hi_sel : lo_sel;
  end

endmodule

// File: rtl/tristate_bus_reader.sv
// Receive-side controller: arbitrates driver requests, grants one driver,
// waits for its echo, captures the bus word and offers it downstream.
module tristate_bus_reader
  import tristate_bus_reader_pkg::*;
#(
  parameter int N_BITS  = DEF_N_BITS,
  parameter int N_SRC   = DEF_N_SRC,
  parameter int TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  tristate_bus_reader_if.master bus,
  output logic                  err_timeout,
  output logic                  err_contention,
  output logic                  busy
);

  localparam int SRC_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [N_SRC-1:0]  grant_q;
  logic [N_BITS-1:0] data_q;
  logic [SRC_W-1:0]  src_q;
  logic              valid_q;
  logic [SRC_W-1:0]  ptr;
  logic [CNT_W-1:0]  wait_cnt;

  logic [SRC_W-1:0]  arb_sel;
  logic              arb_found;
  logic [SRC_W-1:0]  next_ptr;
  logic [N_SRC-1:0]  sel_grant;
  logic [CNT_W-1:0]  cnt_inc;
  logic              contention;

  rr_arbiter #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .sel   (arb_sel),
    .found (arb_found)
  );

  assign next_ptr   = (arb_sel == SRC_W'(N_SRC - 1)) ? '0 : arb_sel + 1'b1;
  assign sel_grant  = N_SRC'(onehot(src_idx_t'(arb_sel)));
  assign cnt_inc    = wait_cnt + 1'b1;
  assign contention = popcount_gt1(src_vec_t'(bus.bus_ctl));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      grant_q        <= '0;
      data_q         <= '0;
      src_q          <= '0;
      valid_q        <= 1'b0;
      ptr            <= '0;
      wait_cnt       <= '0;
      err_timeout    <= 1'b0;
      err_contention <= 1'b0;
      busy           <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      if (contention) begin
        err_contention <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            grant_q <= sel_grant;
            src_q   <= arb_sel;
            ptr     <= next_ptr;
            busy    <= 1'b1;
            state   <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end

        ST_WAIT: begin
          // A capture beats a timeout landing in the same cycle.
          if (bus.bus_ctl[src_q]) begin
            data_q  <= bus.bus_data;
            grant_q <= '0;
            valid_q <= 1'b1;
            state   <= ST_HOLD;
          end else begin
            wait_cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(TIMEOUT)) begin
              grant_q     <= '0;
              err_timeout <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_IDLE;
            end
          end
        end

        ST_HOLD: begin
          if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: begin
          grant_q <= '0;
          valid_q <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Directed bench for tristate_bus_reader with a registered-enable driver model.
module tb_tristate_bus_reader;

  localparam int N_BITS  = 32;
  localparam int N_SRC   = 4;
  localparam int TIMEOUT = 4;

  logic clk;
  logic reset;
  logic err_timeout;
  logic err_contention;
  logic busy;

  logic [N_SRC-1:0]  drv_en;
  logic [N_SRC-1:0]  mute;
  logic [N_SRC-1:0]  ctl_force;
  logic [N_BITS-1:0] src_word [N_SRC];
  logic [N_BITS-1:0] bus_mux;

  int total;
  int bad;

  tristate_bus_reader_if #(.N_BITS(N_BITS), .N_SRC(N_SRC)) bus_if ();

  tristate_bus_reader #(
    .N_BITS  (N_BITS),
    .N_SRC   (N_SRC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus_if),
    .err_timeout    (err_timeout),
    .err_contention (err_contention),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each driver registers its enable; a muted driver never answers.
  initial drv_en = '0;
  always @(posedge clk) drv_en <= bus_if.grant & ~mute;

  always_comb begin
    bus_mux = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (drv_en[k]) bus_mux = bus_mux | src_word[k];
    end
  end

  assign bus_if.bus_ctl  = drv_en | ctl_force;
  assign bus_if.bus_data = bus_mux;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until a grant appears (bounded); leaves the bench in cycle T.
  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    tick();
    while (bus_if.grant == '0 && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_grant_seen"}, 64'(bus_if.grant != '0), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    src_word[0] = 32'h1111_0000;
    src_word[1] = 32'h2222_0001;
    src_word[2] = 32'hDEAD_BEEF;
    src_word[3] = 32'h4444_0003;
    mute             = '0;
    ctl_force        = '0;
    bus_if.req       = '0;
    bus_if.out_ready = 1'b1;
    reset            = 1'b0;

    repeat (3) tick();
    check("rst_grant", bus_if.grant, 0);
    check("rst_valid", bus_if.out_valid, 0);
    check("rst_data", bus_if.out_data, 0);
    check("rst_src", bus_if.out_src, 0);
    check("rst_errs", {err_timeout, err_contention, busy}, 0);
    reset = 1'b1;
    tick();

    // Round-robin: all requesting, expected order 0,1,2,3,0.
    bus_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr");
      check("rr_grant", bus_if.grant, 64'(1 << (k % 4)));
      tick();
      tick();
      check("rr_valid", bus_if.out_valid, 1);
      check("rr_src", bus_if.out_src, 64'(k % 4));
      check("rr_data", bus_if.out_data, src_word[k % 4]);
      if (k == 4) bus_if.req = '0;
    end
    tick();
    check("rr_idle", busy, 0);
    check("rr_no_contention", err_contention, 0);

    // Single request from driver 2: two-cycle grant, word at T+2, idle at T+3.
    bus_if.req = 4'b0100;
    wait_grant("single");
    bus_if.req = '0;
    check("single_grant_t0", bus_if.grant, 4'b0100);
    check("single_busy", busy, 1);
    tick();
    check("single_grant_t1", bus_if.grant, 4'b0100);
    check("single_valid_t1", bus_if.out_valid, 0);
    tick();
    check("single_grant_t2", bus_if.grant, 0);
    check("single_valid_t2", bus_if.out_valid, 1);
    check("single_data", bus_if.out_data, 32'hDEAD_BEEF);
    check("single_src", bus_if.out_src, 2);
    tick();
    check("single_valid_t3", bus_if.out_valid, 0);
    check("single_idle_t3", busy, 0);

    // Backpressure: word held for 5 cycles, released the cycle after ready.
    bus_if.out_ready = 1'b0;
    bus_if.req = 4'b1000;
    wait_grant("bp");
    bus_if.req = '0;
    tick();
    tick();
    check("bp_valid", bus_if.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", bus_if.out_valid, 1);
      check("bp_hold_data", bus_if.out_data, src_word[3]);
      check("bp_hold_src", bus_if.out_src, 3);
      check("bp_hold_grant", bus_if.grant, 0);
    end
    bus_if.out_ready = 1'b1;
    tick();
    check("bp_release_valid", bus_if.out_valid, 0);
    check("bp_release_idle", busy, 0);

    // Timeout: driver 1 is silent; grant spans GRANT plus 4 WAIT cycles.
    mute = 4'b0010;
    bus_if.req = 4'b0010;
    wait_grant("to");
    bus_if.req = '0;
    check("to_grant_t0", bus_if.grant, 4'b0010);
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      check("to_grant_wait", bus_if.grant, 4'b0010);
      check("to_no_pulse_yet", err_timeout, 0);
      check("to_no_valid", bus_if.out_valid, 0);
    end
    tick();
    check("to_grant_dropped", bus_if.grant, 0);
    check("to_pulse", err_timeout, 1);
    check("to_valid_never", bus_if.out_valid, 0);
    check("to_idle", busy, 0);
    tick();
    check("to_pulse_end", err_timeout, 0);
    mute = '0;

    // Contention: two enables for one cycle; flag stays set afterwards.
    ctl_force = 4'b0011;
    tick();
    ctl_force = '0;
    check("cont_set", err_contention, 1);
    bus_if.req = 4'b0001;
    wait_grant("cont");
    bus_if.req = '0;
    tick();
    tick();
    check("cont_xfer_src", bus_if.out_src, 0);
    check("cont_xfer_data", bus_if.out_data, src_word[0]);
    tick();
    check("cont_sticky", err_contention, 1);

    // Reset mid-WAIT; afterwards the pointer must be back at 0.
    mute = 4'b0100;
    bus_if.req = 4'b0100;
    wait_grant("mid");
    bus_if.req = '0;
    tick();
    check("mid_in_wait", bus_if.grant, 4'b0100);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_grant", bus_if.grant, 0);
    check("mid_rst_valid", bus_if.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_contention", err_contention, 0);
    tick();
    reset = 1'b1;
    mute = '0;
    bus_if.req = 4'b1001;
    wait_grant("post");
    bus_if.req = '0;
    check("post_grant_src0", bus_if.grant, 4'b0001);
    tick();
    tick();
    check("post_src", bus_if.out_src, 0);
    check("post_valid", bus_if.out_valid, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
